// File: rtl/npu_activation_pipe.sv
// Three-stage activation pipeline: identity / ReLU / piecewise sigmoid / tanh on signed Q.8 input,
// producing saturated Q7.8 output with a valid/ready handshake and a pass-through tag.
module npu_activation_pipe #(
  parameter int unsigned DIN_W = 48,
  parameter int unsigned TAG_W = 4
) (
  input  logic               CLK,
  input  logic               npu_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIN_W-1:0]   in_data,
  input  logic [1:0]         in_func,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  output logic               out_sat,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned XW = DIN_W + 2;
  localparam logic [1:0] F_ID   = 2'd0;
  localparam logic [1:0] F_RELU = 2'd1;
  localparam logic [1:0] F_SIG  = 2'd2;
  localparam logic [1:0] F_TANH = 2'd3;
  localparam logic signed [DIN_W-1:0] MAXV  = {{(DIN_W-16){1'b0}}, 16'h7FFF};
  localparam logic signed [DIN_W-1:0] MINV  = {{(DIN_W-16){1'b1}}, 16'h8000};
  localparam logic signed [XW-1:0]    A_MAX = XW'(1280);

  logic                    w_adv;
  logic signed [DIN_W-1:0] w_x;
  logic signed [XW-1:0]    w_xe;
  logic signed [XW-1:0]    w_xs;
  logic signed [XW-1:0]    w_abs;
  logic                    w_neg;
  logic [10:0]             w_a;
  logic [15:0]             w_lin;
  logic                    w_lsat;
  logic                    w_pos_ovf;
  logic                    w_neg_ovf;
  logic [8:0]              w_y;
  logic [8:0]              w_s;
  logic [15:0]             w_res;

  logic               r1_v, r2_v;
  logic [1:0]         r1_func, r2_func;
  logic [TAG_W-1:0]   r1_tag, r2_tag;
  logic               r1_neg, r2_neg;
  logic [10:0]        r1_a;
  logic [8:0]         r2_y;
  logic [15:0]        r1_lin, r2_lin;
  logic               r1_sat, r2_sat;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // S1: linear clamp for identity/ReLU, |x| (or |2x|) limited to 1280 for sigmoid/tanh
  assign w_x       = $signed(in_data);
  assign w_pos_ovf = (w_x > MAXV);
  assign w_neg_ovf = (w_x < MINV);
  assign w_xe      = XW'(w_x);
  assign w_xs      = (in_func == F_TANH) ? (w_xe <<< 1) : w_xe;
  assign w_neg     = w_xs[XW-1];
  assign w_abs     = w_neg ? -w_xs : w_xs;
  assign w_a       = (w_abs >= A_MAX) ? 11'd1280 : w_abs[10:0];

  always_comb begin
    w_lin  = 16'h0000;
    w_lsat = 1'b0;
    case (in_func)
      F_ID: begin
        if (w_pos_ovf) begin
          w_lin  = 16'h7FFF;
          w_lsat = 1'b1;
        end else if (w_neg_ovf) begin
          w_lin  = 16'h8000;
          w_lsat = 1'b1;
        end else begin
          w_lin = w_x[15:0];
        end
      end
      F_RELU: begin
        if (w_x[DIN_W-1]) begin
          w_lin = 16'h0000;
        end else if (w_pos_ovf) begin
          w_lin  = 16'h7FFF;
          w_lsat = 1'b1;
        end else begin
          w_lin = w_x[15:0];
        end
      end
      default: begin
        w_lin  = 16'h0000;
        w_lsat = 1'b0;
      end
    endcase
  end

  // S2: piecewise-linear sigmoid magnitude segment
  always_comb begin
    w_y = 9'd0;
    if (r1_a >= 11'd1280)     w_y = 9'd256;
    else if (r1_a >= 11'd608) w_y = 9'(r1_a >> 5) + 9'd216;
    else if (r1_a >= 11'd256) w_y = 9'(r1_a >> 3) + 9'd160;
    else                      w_y = 9'(r1_a >> 2) + 9'd128;
  end

  // S3: mirror for negative inputs, rescale for tanh
  always_comb begin
    w_s   = r2_neg ? (9'd256 - r2_y) : r2_y;
    w_res = r2_lin;
    case (r2_func)
      F_SIG:   w_res = 16'(w_s);
      F_TANH:  w_res = 16'({w_s, 1'b0}) - 16'd256;
      default: w_res = r2_lin;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!npu_rst_n) begin
      r1_v      <= 1'b0;
      r1_func   <= 2'd0;
      r1_tag    <= '0;
      r1_neg    <= 1'b0;
      r1_a      <= 11'd0;
      r1_lin    <= 16'h0000;
      r1_sat    <= 1'b0;
      r2_v      <= 1'b0;
      r2_func   <= 2'd0;
      r2_tag    <= '0;
      r2_neg    <= 1'b0;
      r2_y      <= 9'd0;
      r2_lin    <= 16'h0000;
      r2_sat    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_sat   <= 1'b0;
      out_tag   <= '0;
    end else if (w_adv) begin
      r1_v      <= in_valid;
      r1_func   <= in_func;
      r1_tag    <= in_tag;
      r1_neg    <= w_neg;
      r1_a      <= w_a;
      r1_lin    <= w_lin;
      r1_sat    <= w_lsat;
      r2_v      <= r1_v;
      r2_func   <= r1_func;
      r2_tag    <= r1_tag;
      r2_neg    <= r1_neg;
      r2_y      <= w_y;
      r2_lin    <= r1_lin;
      r2_sat    <= r1_sat;
      out_valid <= r2_v;
      out_data  <= w_res;
      out_sat   <= r2_sat;
      out_tag   <= r2_tag;
    end
  end

endmodule

// File: tb/tb_npu_activation_pipe.sv
// Scoreboard bench for npu_activation_pipe: directed vectors push expected results,
// an independent monitor pops and checks on every output handshake.
module tb_npu_activation_pipe;

  logic        CLK = 1'b0;
  logic        npu_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [1:0]  in_func;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [3:0]  out_tag;

  typedef struct {
    logic [15:0] d;
    logic        s;
    logic [3:0]  t;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  npu_activation_pipe #(.DIN_W(48), .TAG_W(4)) dut (
    .CLK       (CLK),
    .npu_rst_n (npu_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_func   (in_func),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_tag   (out_tag)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [47:0] d, input logic [1:0] f, input logic [3:0] t,
                      input logic [15:0] ed, input logic es, input bit rnd);
    int  tries = 0;
    bit  done  = 0;
    exp_t e;
    while (!done) begin
      @(negedge CLK);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_func   = f;
      in_tag    = t;
      #1;
      if (in_ready) begin
        e.d = ed; e.s = es; e.t = t; e.cyc = cyc; e.chk_lat = !rnd;
        sb.push_back(e);
        done = 1;
      end else if (++tries > 50) begin
        chk("accept_timeout", 32'(tries), 32'd0);
        done = 1;
      end
    end
  endtask

  task automatic idle(input bit rnd);
    @(negedge CLK);
    in_valid  = 1'b0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      idle(1'b0);
      #3;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) idle(1'b0);
  endtask

  // Monitor: pops on every handshake, checks hold stability while stalled
  logic        stalled_prev = 1'b0;
  logic [15:0] held_d;
  logic        held_s;
  logic [3:0]  held_t;

  always begin
    exp_t e;
    @(negedge CLK);
    #2;
    if (stalled_prev && out_valid) begin
      chk("stall_hold", {11'd0, out_sat, out_tag, out_data}, {11'd0, held_s, held_t, held_d});
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {16'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_sat", 32'(out_sat), 32'(e.s));
        chk("out_tag", 32'(out_tag), 32'(e.t));
        if (e.chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
    stalled_prev = out_valid && !out_ready;
    held_d = out_data;
    held_s = out_sat;
    held_t = out_tag;
  end

  initial begin
    npu_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_func   = 2'd0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    npu_rst_n = 1'b1;
    @(negedge CLK);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Sigmoid, back-to-back
    send(48'h0,            2'd2, 4'd0, 16'h0080, 1'b0, 1'b0);
    send(48'h260,          2'd2, 4'd1, 16'h00EB, 1'b0, 1'b0);
    send(48'hFFFFFFFFFDA0, 2'd2, 4'd2, 16'h0015, 1'b0, 1'b0);
    send(48'hF05,          2'd2, 4'd3, 16'h0100, 1'b0, 1'b0);
    // Tanh, identity, ReLU with per-beat mode changes
    send(48'h100,          2'd3, 4'd4, 16'h00C0, 1'b0, 1'b0);
    send(48'hFFFFFFFFFF00, 2'd3, 4'd5, 16'hFF40, 1'b0, 1'b0);
    send(48'h000000FFC7A0, 2'd0, 4'd6, 16'h7FFF, 1'b1, 1'b0);
    send(48'hFFFFFFFFFDA0, 2'd1, 4'd7, 16'h0000, 1'b0, 1'b0);
    // Most negative input in every mode
    send(48'h800000000000, 2'd0, 4'd8, 16'h8000, 1'b1, 1'b0);
    send(48'h800000000000, 2'd1, 4'd9, 16'h0000, 1'b0, 1'b0);
    send(48'h800000000000, 2'd2, 4'hA, 16'h0000, 1'b0, 1'b0);
    send(48'h800000000000, 2'd3, 4'hB, 16'hFF00, 1'b0, 1'b0);
    // Clamp and segment boundaries
    send(48'h7FFF,         2'd0, 4'hC, 16'h7FFF, 1'b0, 1'b0);
    send(48'hFFFFFFFF8000, 2'd0, 4'hD, 16'h8000, 1'b0, 1'b0);
    send(48'h8000,         2'd0, 4'hE, 16'h7FFF, 1'b1, 1'b0);
    send(48'h7FFF,         2'd1, 4'hF, 16'h7FFF, 1'b0, 1'b0);
    send(48'h4FF,          2'd2, 4'd0, 16'h00FF, 1'b0, 1'b0);
    send(48'hFF,           2'd2, 4'd1, 16'h00BF, 1'b0, 1'b0);
    send(48'h100,          2'd2, 4'd2, 16'h00C0, 1'b0, 1'b0);
    send(48'hFFFFFFFFFFFF, 2'd2, 4'd3, 16'h0080, 1'b0, 1'b0);
    send(48'h7FFFFFFFFFFF, 2'd3, 4'd4, 16'h0100, 1'b0, 1'b0);
    drain();

    // Tagged stream under random back-pressure
    send(48'h123,          2'd0, 4'd0, 16'h0123, 1'b0, 1'b1);
    send(48'hFFFFFFFFFFFB, 2'd1, 4'd1, 16'h0000, 1'b0, 1'b1);
    send(48'h100,          2'd2, 4'd2, 16'h00C0, 1'b0, 1'b1);
    send(48'h0,            2'd3, 4'd3, 16'h0000, 1'b0, 1'b1);
    send(48'hFFFFFFFFFED4, 2'd0, 4'd4, 16'hFED4, 1'b0, 1'b1);
    send(48'h10000,        2'd1, 4'd5, 16'h7FFF, 1'b1, 1'b1);
    send(48'hFFFFFFFFFB00, 2'd2, 4'd6, 16'h0000, 1'b0, 1'b1);
    send(48'h50,           2'd3, 4'd7, 16'h0050, 1'b0, 1'b1);
    repeat (6) idle(1'b1);
    drain();

    // Reset with two beats in flight discards them
    send(48'h11, 2'd0, 4'd9, 16'h0011, 1'b0, 1'b0);
    send(48'h22, 2'd0, 4'hA, 16'h0022, 1'b0, 1'b0);
    @(negedge CLK);
    in_valid  = 1'b0;
    npu_rst_n = 1'b0;
    sb.delete();
    @(negedge CLK);
    npu_rst_n = 1'b1;
    @(negedge CLK);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge CLK);
      #1;
    end
    send(48'h33, 2'd1, 4'd3, 16'h0033, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_activation_pipe.md
NPU_ACTIVATION_PIPE -- requirements
Module: npu_activation_pipe

Interface
REQ-001 Parameter DIN_W, default 48, SHALL be the signed input width in two's complement Q(DIN_W-8).8; legal range 17..64.
REQ-002 Parameter TAG_W, default 4, SHALL be the width of the sideband tag carried alongside each beat.
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port npu_rst_n, input, 1 bit, SHALL be a synchronous, active-low reset sampled on the rising edge of CLK.
REQ-005 Port in_valid, input, 1 bit, SHALL qualify in_data, in_func and in_tag.
REQ-006 Port in_ready, output, 1 bit, SHALL indicate that the block accepts a beat this cycle.
REQ-007 Port in_data, input, DIN_W bits, SHALL carry the signed Q.8 pre-activation value.
REQ-008 Port in_func, input, 2 bits, SHALL select the function: 0 identity, 1 ReLU, 2 sigmoid, 3 tanh.
REQ-009 Port in_tag, input, TAG_W bits, SHALL carry an opaque tag returned unchanged with the result.
REQ-010 Port out_valid, output, 1 bit, SHALL qualify out_data, out_sat and out_tag.
REQ-011 Port out_ready, input, 1 bit, SHALL indicate that the consumer accepts the output beat.
REQ-012 Port out_data, output, 16 bits, SHALL carry the signed Q7.8 result.
REQ-013 Port out_sat, output, 1 bit, SHALL flag that identity or ReLU clamping occurred.
REQ-014 Port out_tag, output, TAG_W bits, SHALL carry the tag of the beat in out_data.

Function
REQ-015 The datapath SHALL be a 3-stage pipeline: S1 (mode prep and clamp), S2 (segment evaluation), S3 (sign fix and output register).
REQ-016 Define advance = !out_valid || out_ready; all stages SHALL shift only when advance=1.
REQ-017 in_ready SHALL equal advance; a beat is accepted when in_valid && in_ready.
REQ-018 When out_ready is held at 1, latency SHALL be exactly 3 cycles from acceptance to out_valid, at one beat per cycle throughput.
REQ-019 When out_valid && !out_ready, out_data, out_sat and out_tag SHALL be held stable, and no beat SHALL be lost or duplicated.
REQ-020 Bubbles (invalid stages) SHALL propagate as invalid; valid bits SHALL travel with their data.
REQ-021 Identity SHALL output x saturated to [-32768, 32767]; out_sat=1 if clamped.
REQ-022 ReLU SHALL output max(x,0) saturated to 32767; out_sat=1 if clamped.
REQ-023 Sigmoid SHALL use a = min(|x|, 1280), computed without overflow, and evaluate y as follows:
- a>=1280: y=256
- a>=608: y=(a>>5)+216
- a>=256: y=(a>>3)+160
- otherwise: y=(a>>2)+128
REQ-024 Sigmoid output SHALL be y for x>=0 and 256-y for x<0.
REQ-025 Tanh SHALL be computed as 2*sigmoid(2x)-256, where 2x is formed in DIN_W+1 bits before clamping.
REQ-026 For sigmoid and tanh, out_sat SHALL be 0.
REQ-027 The most negative input (-2^(DIN_W-1)) SHALL be handled without wrap in all modes.
REQ-028 in_func and in_tag SHALL be captured per beat; a mode change between consecutive beats SHALL need no idle cycle.

Reset
REQ-029 While npu_rst_n=0 at a CLK edge, all stage valid bits SHALL clear, and the following SHALL be 0: out_valid, out_data, out_sat, out_tag.
REQ-030 in_ready SHALL be 1 in the cycle after reset releases.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats; no result for them SHALL appear after release.

Verification
REQ-032 Sigmoid, out_ready=1, inputs 0x0, 0x260, 0xFFFFFFFFFDA0, 0xF05 on consecutive cycles -> out_data 0x0080, 0x00EB, 0x0015, 0x0100, each 3 cycles after acceptance.
REQ-033 Tanh, in_data=0x100 -> out_data 0x00C0; in_data=0xFFFFFFFFFF00 -> 0xFF40.
REQ-034 Identity, in_data=0x000000FFC7A0 -> out_data 0x7FFF, out_sat=1; ReLU, in_data=0xFFFFFFFFFDA0 -> 0x0000, out_sat=0.
REQ-035 Stream 8 beats with tags 0..7 while out_ready toggles pseudo-randomly -> all 8 results emerge in order with matching tags, and outputs stay stable while stalled.
REQ-036 Accept 2 beats, then drive npu_rst_n=0 for 1 cycle -> out_valid stays 0 afterwards until new input is accepted.
REQ-037 Identity, in_data=0x800000000000 -> out_data 0x8000, out_sat=1.
